// File: rtl/output_quantize_feed_pkg.sv
// Shared definitions for the output pipeline: FSM states, store word size
// and the byte clamp limits.
package output_quantize_feed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_PAD,
        ST_GAP
    } feed_state_t;

    // Bytes per 128-bit store word; frames are padded to a multiple of this.
    localparam int GROUP_BYTES = 16;

    localparam logic [7:0] BYTE_MIN = 8'h00;
    localparam logic [7:0] BYTE_MAX = 8'hFF;

endpackage

// File: rtl/output_quantize_feed_requant.sv
// requant_pipe: multiply / round / shift / clamp datapath with a valid
// sideband. Fixed latency: a value captured at edge E0 is on out_byte
// after edge E3. A pad request loads a 0x00 byte straight into the
// output register.
module requant_pipe
    import output_quantize_feed_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int SCALE_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_vld,
    input  logic signed [ACC_W-1:0] in_data,
    input  logic [SCALE_W-1:0]      scale,
    input  logic [4:0]              shift,
    input  logic                    pad,
    output logic                    busy,
    output logic                    out_load,
    output logic                    out_vld,
    output logic [7:0]              out_byte
);

    localparam int PW = ACC_W + SCALE_W + 1;

    // [0]=S1, [1]=S2, [2]=S3
    logic [2:0]              vld_pipe;
    logic signed [ACC_W-1:0] s1_acc;
    logic signed [PW-1:0]    s2_prod;
    logic signed [PW-1:0]    s3_val;

    logic signed [PW-1:0]    acc_ext;
    logic signed [PW-1:0]    scl_ext;
    logic signed [PW-1:0]    rnd;
    logic [7:0]              clamped;

    assign acc_ext  = {{(PW-ACC_W){s1_acc[ACC_W-1]}}, s1_acc};
    assign scl_ext  = {{(PW-SCALE_W){1'b0}}, scale};
    assign busy     = |vld_pipe;
    assign out_load = vld_pipe[2] | pad;

    // Round-half-up constant; zero when no shift is requested.
    always_comb begin
        rnd = '0;
        if (shift != 5'd0)
            rnd = PW'(1) << (shift - 5'd1);
    end

    // Saturate the shifted value into an unsigned byte.
    always_comb begin
        clamped = s3_val[7:0];
        if (s3_val[PW-1])
            clamped = BYTE_MIN;
        else if (|s3_val[PW-2:8])
            clamped = BYTE_MAX;
    end

    // Pipeline registers: capture, multiply, round/shift, clamp.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_acc   <= '0;
            s2_prod  <= '0;
            s3_val   <= '0;
            out_vld  <= 1'b0;
            out_byte <= 8'h00;
        end else begin
            vld_pipe <= {vld_pipe[1:0], in_vld};
            s1_acc   <= in_data;
            s2_prod  <= acc_ext * scl_ext;
            s3_val   <= (s2_prod + rnd) >>> shift;
            out_vld  <= out_load;
            out_byte <= vld_pipe[2] ? clamped : 8'h00;
        end
    end

endmodule

// File: rtl/output_quantize_feed.sv
// Output quantize feed: requantizes a signed accumulator stream into the
// store's start/result byte interface, fills bubbles with gap bytes, pads
// each frame to a whole store word and inserts a one-cycle start gap.
module output_quantize_feed
    import output_quantize_feed_pkg::*;
#(
    parameter int ACC_W       = 32,
    parameter int SCALE_W     = 16,
    parameter int GROUP_BYTES = output_quantize_feed_pkg::GROUP_BYTES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ACC_W-1:0]   AccIn,
    input  logic               AccValid,
    input  logic               AccLast,
    output logic               AccReady,
    input  logic [SCALE_W-1:0] Scale,
    input  logic [4:0]         Shift,
    output logic               StartOut,
    output logic [7:0]         ResultOut,
    output logic               FrameDone,
    output logic               GapError,
    output logic [15:0]        ByteCount
);

    localparam logic [15:0] GB_MASK = 16'(GROUP_BYTES - 1);

    feed_state_t        state;
    logic [SCALE_W-1:0] scale_q;
    logic [4:0]         shift_q;

    logic               xfer;
    logic               frame_start;
    logic               bubble;
    logic               pipe_vld;
    logic [ACC_W-1:0]   pipe_data;
    logic               busy;
    logic               out_load;
    logic               tail;
    logic               aligned;
    logic               emit_pad;

    assign xfer        = AccValid & AccReady;
    assign frame_start = xfer && (state == ST_IDLE);
    // A missing value inside a frame still occupies a byte slot (as zero).
    assign bubble      = (state == ST_RUN) && !AccValid;
    assign pipe_vld    = xfer | bubble;
    assign pipe_data   = AccValid ? AccIn : '0;
    // Tail phase: all real bytes are out (or already padding).
    assign tail        = ((state == ST_DRAIN) && !busy) || (state == ST_PAD);
    assign aligned     = (ByteCount & GB_MASK) == 16'd0;
    assign emit_pad    = tail && !aligned;

    requant_pipe #(
        .ACC_W   (ACC_W),
        .SCALE_W (SCALE_W)
    ) u_pipe (
        .clock    (clock),
        .reset    (reset),
        .in_vld   (pipe_vld),
        .in_data  (pipe_data),
        .scale    (scale_q),
        .shift    (shift_q),
        .pad      (emit_pad),
        .busy     (busy),
        .out_load (out_load),
        .out_vld  (StartOut),
        .out_byte (ResultOut)
    );

    // Frame FSM with registered handshake, done pulse and sticky gap flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            AccReady  <= 1'b1;
            FrameDone <= 1'b0;
            GapError  <= 1'b0;
            scale_q   <= '0;
            shift_q   <= '0;
        end else begin
            FrameDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (AccValid) begin
                        scale_q  <= Scale;
                        shift_q  <= Shift;
                        GapError <= 1'b0;
                        if (AccLast) begin
                            state    <= ST_DRAIN;
                            AccReady <= 1'b0;
                        end else begin
                            state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!AccValid) begin
                        GapError <= 1'b1;
                    end else if (AccLast) begin
                        state    <= ST_DRAIN;
                        AccReady <= 1'b0;
                    end
                end
                ST_DRAIN, ST_PAD: begin
                    if (tail && aligned) begin
                        state     <= ST_GAP;
                        FrameDone <= 1'b1;
                    end else if (tail) begin
                        state     <= ST_PAD;
                    end
                end
                ST_GAP: begin
                    state    <= ST_IDLE;
                    AccReady <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    AccReady <= 1'b1;
                end
            endcase
        end
    end

    // Byte counter: value includes the byte currently on ResultOut.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ByteCount <= 16'd0;
        else if (frame_start)
            ByteCount <= 16'd0;
        else if (out_load)
            ByteCount <= ByteCount + 16'd1;
    end

endmodule

// File: tb/tb_output_quantize_feed.sv
// Randomized scoreboard bench for output_quantize_feed.
module tb_output_quantize_feed;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] AccIn;
    logic        AccValid;
    logic        AccLast;
    logic        AccReady;
    logic [15:0] Scale;
    logic [4:0]  Shift;
    logic        StartOut;
    logic [7:0]  ResultOut;
    logic        FrameDone;
    logic        GapError;
    logic [15:0] ByteCount;

    output_quantize_feed dut (
        .clock     (clock),
        .reset     (reset),
        .AccIn     (AccIn),
        .AccValid  (AccValid),
        .AccLast   (AccLast),
        .AccReady  (AccReady),
        .Scale     (Scale),
        .Shift     (Shift),
        .StartOut  (StartOut),
        .ResultOut (ResultOut),
        .FrameDone (FrameDone),
        .GapError  (GapError),
        .ByteCount (ByteCount)
    );

    initial forever #5 clock = ~clock;

    typedef struct { logic [7:0] b; int cnt; bit first; } exp_t;
    typedef struct { int cnt; bit gap; } done_t;

    exp_t        byte_q[$];
    done_t       done_q[$];
    logic [31:0] stim_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          xfer_cyc = 0;
    bit          first_pending = 0;
    bit          mon_en = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference requantization straight from the arithmetic definition.
    function automatic logic [7:0] rq(input longint acc, input longint sc, input int sh);
        longint p;
        p = acc * sc;
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
        p = p >>> sh;
        if (p < 0) return 8'h00;
        if (p > 255) return 8'hFF;
        return p[7:0];
    endfunction

    // Cycle counter and first-transfer timestamp.
    initial forever begin
        @(posedge clock);
        if (first_pending && AccValid && AccReady) begin
            xfer_cyc = cyc + 1;
            first_pending = 0;
        end
        cyc = cyc + 1;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte or done.
    initial begin
        exp_t  e;
        done_t d;
        bit    prev_done;
        prev_done = 0;
        forever begin
            @(negedge clock);
            if (mon_en && !reset) begin
                if (StartOut) begin
                    if (byte_q.size() == 0) chk("unexpected_byte", 1, 0);
                    else begin
                        e = byte_q.pop_front();
                        chk("result_byte", longint'(ResultOut), longint'(e.b));
                        chk("byte_count", longint'(ByteCount), longint'(e.cnt));
                        if (e.first) chk("first_latency", longint'(cyc - xfer_cyc), 3);
                    end
                end
                if (FrameDone) begin
                    if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        d = done_q.pop_front();
                        chk("done_count", longint'(ByteCount), longint'(d.cnt));
                        chk("done_gaperr", longint'(GapError), longint'(d.gap));
                        chk("gap_startout", longint'(StartOut), 0);
                        chk("gap_ready", longint'(AccReady), 0);
                    end
                end
                if (prev_done) begin
                    chk("done_pulse_len", longint'(FrameDone), 0);
                    chk("ready_after_gap", longint'(AccReady), 1);
                end
                prev_done = FrameDone;
            end else begin
                prev_done = 0;
            end
        end
    end

    task automatic send(input logic [31:0] v, input bit last, input bit first);
        int w;
        @(negedge clock);
        AccValid = 1'b1; AccIn = v; AccLast = last;
        if (first) first_pending = 1;
        w = 0;
        while (!AccReady && w < 100) begin @(negedge clock); w++; end
        if (!AccReady) chk("ready_timeout", 0, 1);
        @(posedge clock);
    endtask

    // Drive one frame from stim_q and push its expected bytes.
    task automatic frame(input int n, input int bub_after, input int bub_rate,
                         input int sc, input int sh, input bit hold);
        int cnt;
        bit gap;
        cnt = 0; gap = 0;
        Scale = 16'(sc); Shift = 5'(sh);
        for (int i = 0; i < n; i++) begin
            send(stim_q[i], i == n - 1, i == 0);
            byte_q.push_back('{rq(longint'($signed(stim_q[i])), sc, sh), cnt + 1, i == 0});
            cnt++;
            if (i == 0) begin
                #1;
                chk("gaperr_clear", longint'(GapError), 0);
                Scale = 16'($urandom); Shift = 5'($urandom);
            end
            if (i == n - 1) begin
                @(negedge clock);
                chk("ready_low_after_last", longint'(AccReady), 0);
                if (!hold) AccValid = 1'b0;
            end else if (i == bub_after - 1 || (bub_rate > 0 && int'($urandom_range(99)) < bub_rate)) begin
                @(negedge clock);
                AccValid = 1'b0; AccLast = 1'b0; AccIn = $urandom;
                @(posedge clock);
                byte_q.push_back('{8'h00, cnt + 1, 1'b0});
                cnt++; gap = 1;
            end
        end
        while (cnt % 16 != 0) begin
            byte_q.push_back('{8'h00, cnt + 1, 1'b0});
            cnt++;
        end
        done_q.push_back('{cnt, gap});
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((byte_q.size() != 0 || done_q.size() != 0) && w < 3000) begin
            @(negedge clock); w++;
        end
        chk("drain_timeout", longint'(byte_q.size() + done_q.size()), 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic ramp_frame();
        stim_q.delete();
        for (int k = 0; k < 16; k++) stim_q.push_back(32'(k * 256));
        frame(16, 0, 0, 1, 8, 0);
    endtask

    initial begin
        bit found;
        reset = 1'b1; AccIn = '0; AccValid = 1'b0; AccLast = 1'b0;
        Scale = '0; Shift = '0;
        #12;
        chk("rst_ready", longint'(AccReady), 1);
        chk("rst_start", longint'(StartOut), 0);
        chk("rst_result", longint'(ResultOut), 0);
        chk("rst_done", longint'(FrameDone), 0);
        chk("rst_gaperr", longint'(GapError), 0);
        chk("rst_count", longint'(ByteCount), 0);
        @(negedge clock); reset = 1'b0; mon_en = 1;

        // Ramp frame: exactly one store word, no pads.
        ramp_frame();
        wait_drain();

        // Single negative value, clamped, padded to 16.
        stim_q.delete(); stim_q.push_back(-32'sd5);
        frame(1, 0, 0, 7, 0, 0);
        wait_drain();

        // Rounding and saturation.
        stim_q.delete();
        stim_q.push_back(32'd5); stim_q.push_back(32'd6); stim_q.push_back(32'd100000);
        frame(3, 0, 0, 3, 2, 0);
        wait_drain();

        // 20 values with one bubble after value 10, then a frame that clears GapError.
        stim_q.delete();
        for (int k = 0; k < 20; k++) stim_q.push_back(32'($urandom_range(4000)) - 32'd1000);
        frame(20, 10, 0, 5, 4, 0);
        wait_drain();

        // Back-to-back frames with AccValid held across AccLast.
        stim_q.delete();
        for (int k = 0; k < 5; k++) stim_q.push_back(32'($urandom_range(2000)));
        frame(5, 0, 0, 2, 3, 1);
        stim_q.delete();
        for (int k = 0; k < 7; k++) stim_q.push_back(32'($urandom_range(2000)));
        frame(7, 0, 0, 9, 5, 0);
        wait_drain();

        // Reset in the middle of a frame while byte 7 is on the output.
        mon_en = 0; found = 0;
        Scale = 16'd1; Shift = 5'd8;
        for (int k = 0; k < 16 && !found; k++) begin
            send(32'(k * 256), k == 15, 1'b0);
            #1;
            if (StartOut && ByteCount == 16'd7) found = 1;
        end
        chk("reached_byte7", longint'(found), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_start", longint'(StartOut), 0);
        chk("async_rst_result", longint'(ResultOut), 0);
        chk("async_rst_count", longint'(ByteCount), 0);
        chk("async_rst_done", longint'(FrameDone), 0);
        chk("async_rst_ready", longint'(AccReady), 1);
        AccValid = 1'b0; AccLast = 1'b0; first_pending = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0; mon_en = 1;
        ramp_frame();
        wait_drain();

        // Random frames with random bubbles and back-to-back holds.
        for (int f = 0; f < 10; f++) begin
            int n;
            n = int'($urandom_range(1, 40));
            stim_q.delete();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3) == 0) stim_q.push_back($urandom);
                else stim_q.push_back(32'($urandom_range(3000)) - 32'd800);
            end
            frame(n, 0, 15, int'($urandom_range(300)), int'($urandom_range(12)), 1'($urandom_range(1)));
        end
        AccValid = 1'b0;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
